// File: rtl/even_result_forward_pipe_pkg.sv
// Shared types and default stage positions for the even-pipe result forwarding block.
package even_result_forward_pipe_pkg;

  // Result and register-address widths; the entry struct is built from these.
  localparam int unsigned DataW = 128;
  localparam int unsigned AddrW = 7;

  // Default stage numbers, counted in the same frame as the execution unit.
  localparam int unsigned DefFpLat   = 6;
  localparam int unsigned DefIntLat  = 7;
  localparam int unsigned DefWbStage = 8;
  localparam int unsigned DefCommit  = 7;

  // One in-flight result: valid flag, destination register and value.
  typedef struct packed {
    logic             v;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } pipe_entry_t;

  // Pack an insertion into an entry.
  function automatic pipe_entry_t make_entry(logic             v,
                                             logic [AddrW-1:0] addr,
                                             logic [DataW-1:0] data);
    pipe_entry_t e;
    e.v    = v;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // A stage below the commit point is still speculative and dies on a flush.
  function automatic logic is_uncommitted(int unsigned stage, int unsigned commit);
    return stage < commit;
  endfunction

endpackage

// File: rtl/even_result_forward_pipe_fwd_select.sv
// Priority mux: youngest matching in-flight result for one operand, else the register table.
module even_result_forward_pipe_fwd_select
  import even_result_forward_pipe_pkg::*;
#(
  parameter int unsigned NumStages = 3
) (
  input  pipe_entry_t [NumStages-1:0] entries_i,
  input  logic        [AddrW-1:0]     addr_i,
  input  logic        [DataW-1:0]     rf_i,
  output logic        [DataW-1:0]     fwd_o
);

  // Index 0 is the youngest stage, so the first hit scanning upward wins.
  always_comb begin
    logic found;
    fwd_o = rf_i;
    found = 1'b0;
    for (int unsigned i = 0; i < NumStages; i++) begin
      if (!found && entries_i[i].v && (entries_i[i].addr == addr_i)) begin
        fwd_o = entries_i[i].data;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/even_result_forward_pipe.sv
// Carries FP and integer-multiply results from their insertion stages to write back,
// drives the register-table write port and forwards in-flight results to operand fetch.
module even_result_forward_pipe
  import even_result_forward_pipe_pkg::*;
#(
  parameter int unsigned FpLat   = DefFpLat,
  parameter int unsigned IntLat  = DefIntLat,
  parameter int unsigned WbStage = DefWbStage,
  parameter int unsigned Commit  = DefCommit
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // FP results
  input  logic             fp_we_i,
  input  logic [AddrW-1:0] fp_addr_i,
  input  logic [DataW-1:0] fp_data_i,
  // Integer-multiply results
  input  logic             int_we_i,
  input  logic [AddrW-1:0] int_addr_i,
  input  logic [DataW-1:0] int_data_i,
  // Branch-taken flush
  input  logic             flush_i,
  // Operand fetch of the issuing instruction
  input  logic [AddrW-1:0] ra_addr_i,
  input  logic [AddrW-1:0] rb_addr_i,
  input  logic [AddrW-1:0] rc_addr_i,
  input  logic [DataW-1:0] ra_rf_i,
  input  logic [DataW-1:0] rb_rf_i,
  input  logic [DataW-1:0] rc_rf_i,
  output logic [DataW-1:0] ra_fwd_o,
  output logic [DataW-1:0] rb_fwd_o,
  output logic [DataW-1:0] rc_fwd_o,
  // Register-table write port
  output logic             wb_we_o,
  output logic [AddrW-1:0] wb_addr_o,
  output logic [DataW-1:0] wb_data_o,
  output logic             collision_err_o
);

  // Entry index i holds stage FpLat + i; index 0 is the youngest.
  localparam int unsigned NumStages = WbStage - FpLat + 1;
  localparam int unsigned IntIdx    = IntLat - FpLat;
  localparam int unsigned WbIdx     = NumStages - 1;

  pipe_entry_t [NumStages-1:0] stage_q, stage_d;
  logic                        collision_q, collision_d;

  // Shift, insert and flush. addr/data only load with a surviving valid entry, so an
  // idle stage (and therefore the write-back port) keeps its last real result.
  always_comb begin
    pipe_entry_t in_e;
    logic        kill;
    logic        keep;

    stage_d = stage_q;

    // FP insertion at the youngest stage.
    in_e = make_entry(fp_we_i, fp_addr_i, fp_data_i);
    kill = flush_i & is_uncommitted(FpLat, Commit);
    keep = in_e.v & ~kill;
    stage_d[0].v = keep;
    if (keep) begin
      stage_d[0].addr = in_e.addr;
      stage_d[0].data = in_e.data;
    end

    // Older stages take the shifted entry, or the integer result at its insertion stage.
    // An entry still in an uncommitted stage at a flush edge is killed as it moves on.
    for (int unsigned i = 1; i < NumStages; i++) begin
      if ((i == IntIdx) && int_we_i) begin
        in_e = make_entry(1'b1, int_addr_i, int_data_i);
        kill = flush_i & is_uncommitted(IntLat, Commit);
      end else begin
        in_e = stage_q[i-1];
        kill = flush_i & is_uncommitted(FpLat + i - 1, Commit);
      end
      keep = in_e.v & ~kill;
      stage_d[i].v = keep;
      if (keep) begin
        stage_d[i].addr = in_e.addr;
        stage_d[i].data = in_e.data;
      end
    end
  end

  // An integer insertion overwrites whatever valid entry was about to shift into its stage.
  always_comb begin
    collision_d = collision_q | (int_we_i & stage_q[IntIdx-1].v);
  end

  // Entry array and sticky collision flag; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      collision_q <= collision_d;
    end
  end

  // Write back straight from the last stage registers.
  always_comb begin
    wb_we_o         = stage_q[WbIdx].v;
    wb_addr_o       = stage_q[WbIdx].addr;
    wb_data_o       = stage_q[WbIdx].data;
    collision_err_o = collision_q;
  end

  even_result_forward_pipe_fwd_select #(
    .NumStages (NumStages)
  ) u_fwd_ra (
    .entries_i (stage_q),
    .addr_i    (ra_addr_i),
    .rf_i      (ra_rf_i),
    .fwd_o     (ra_fwd_o)
  );

  even_result_forward_pipe_fwd_select #(
    .NumStages (NumStages)
  ) u_fwd_rb (
    .entries_i (stage_q),
    .addr_i    (rb_addr_i),
    .rf_i      (rb_rf_i),
    .fwd_o     (rb_fwd_o)
  );

  even_result_forward_pipe_fwd_select #(
    .NumStages (NumStages)
  ) u_fwd_rc (
    .entries_i (stage_q),
    .addr_i    (rc_addr_i),
    .rf_i      (rc_rf_i),
    .fwd_o     (rc_fwd_o)
  );

endmodule
